// File: rtl/aggregator_pkg.sv
// Shared types and helpers for the wavefront aggregator.
package aggregator_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } agg_state_t;

    // Bit width needed to hold values 0..x-1. Never returns less than 1.
    function automatic int cw(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/wavefront_map.sv
// Maps wavefront index k and lane l to the matrix cell (r, c) that the lane
// lands in, and reports whether the lane carries data in that wavefront.
module wavefront_map
    import aggregator_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [cw(2*N)-1:0] k,
    input  logic [cw(N)-1:0]   l,
    output logic [cw(N)-1:0]   r,
    output logic [cw(N)-1:0]   c,
    output logic               active
);
    localparam int IW = cw(N);

    // Anti-diagonal geometry: wavefronts 0..N-1 grow and N..2N-2 shrink.
    // Past the main anti-diagonal, lane 0 starts lower in the matrix.
    always_comb begin
        int ki, li, lim, base, ri, ci;
        ki     = int'(k);
        li     = int'(l);
        lim    = (ki + 1 < 2*N - 1 - ki) ? ki + 1 : 2*N - 1 - ki;
        base   = (ki > N - 1) ? ki - N + 1 : 0;
        ri     = li + base;
        ci     = ki - ri;
        active = (li < lim);
        r      = IW'(ri);
        c      = IW'(ci);
    end

endmodule

// File: rtl/wavefront_aggregator.sv
// Collects 2N-1 anti-diagonal wavefronts into an NxN matrix, then drains it
// as N row vectors, or column vectors when transpose was set at wavefront 0.
module wavefront_aggregator
    import aggregator_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      in_data,
    input  logic                 transpose,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*DW-1:0]      out_data,
    output logic [cw(N)-1:0]     out_idx,
    output logic                 out_last,
    output logic [cw(2*N)-1:0]   wave_cnt
);
    localparam int KW = cw(2*N);
    localparam int IW = cw(N);

    agg_state_t                     state_q, state_d;
    logic [KW-1:0]                  wave_d;
    logic [IW-1:0]                  idx_d;
    logic                           tp_q, tp_d;
    logic [N-1:0][N-1:0][DW-1:0]    mat;

    logic [N-1:0][IW-1:0]           lr, lc;
    logic [N-1:0]                   lact;
    logic                           accept;

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (out_idx == IW'(N-1));
    // abort wins over a wavefront offered in the same cycle
    assign accept    = in_ready && in_valid && !abort;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            wavefront_map #(.N(N)) u_map (
                .k      (wave_cnt),
                .l      (IW'(g)),
                .r      (lr[g]),
                .c      (lc[g]),
                .active (lact[g])
            );
        end
    endgenerate

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            wave_cnt <= '0;
            out_idx  <= '0;
            tp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wave_cnt <= wave_d;
            out_idx  <= idx_d;
            tp_q     <= tp_d;
        end
    end

    // Next-state: count wavefronts in COLLECT, count vectors in DRAIN
    always_comb begin
        state_d = state_q;
        wave_d  = wave_cnt;
        idx_d   = out_idx;
        tp_d    = tp_q;
        case (state_q)
            COLLECT: begin
                if (abort) begin
                    wave_d = '0;
                end else if (in_valid) begin
                    if (wave_cnt == '0)
                        tp_d = transpose;
                    if (wave_cnt == KW'(2*N-2)) begin
                        wave_d  = '0;
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        wave_d = wave_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_idx == IW'(N-1)) begin
                        idx_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        idx_d = out_idx + 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Matrix storage: each active lane overwrites its own distinct cell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat <= '0;
        end else if (accept) begin
            for (int l = 0; l < N; l++)
                if (lact[l])
                    mat[lr[l]][lc[l]] <= in_data[l*DW +: DW];
        end
    end

    // Drain mux: row out_idx, or column out_idx when transposed
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int j = 0; j < N; j++)
                out_data[j*DW +: DW] = tp_q ? mat[j][out_idx] : mat[out_idx][j];
        end
    end

endmodule

// File: tb/tb_wavefront_aggregator.sv
// Directed bench for wavefront_aggregator, N=4, DW=32.
module tb_wavefront_aggregator;
    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic              transpose;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [N*DW-1:0]   out_data;
    logic [1:0]        out_idx;
    logic              out_last;
    logic [2:0]        wave_cnt;

    int errors = 0;
    int checks = 0;

    // Element value of each lane per wavefront, -1 marks an inactive lane
    int wv [0:6][0:3] = '{
        '{ 0, -1, -1, -1},
        '{ 1,  4, -1, -1},
        '{ 2,  5,  8, -1},
        '{ 3,  6,  9, 12},
        '{ 7, 10, 13, -1},
        '{11, 14, -1, -1},
        '{15, -1, -1, -1}
    };

    wavefront_aggregator #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .transpose (transpose),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .wave_cnt  (wave_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Row i holds base+4i+j in lane j; column i holds base+4j+i
    function automatic logic [127:0] vec(input int base, input int i, input bit tp);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            v[j*32 +: 32] = tp ? 32'(base + 4*j + i) : 32'(base + 4*i + j);
        return v;
    endfunction

    // Offers nw wavefronts back to back; transpose is toggled after wavefront 0
    task automatic send(input int base, input bit tp, input bit junk, input int nw);
        for (int k = 0; k < nw; k++) begin
            @(negedge clk);
            chk("in_ready_collect", in_ready, 1);
            chk("wave_cnt", wave_cnt, k);
            in_valid  = 1'b1;
            transpose = (k == 0) ? tp : ~tp;
            for (int l = 0; l < N; l++)
                in_data[l*32 +: 32] = (wv[k][l] < 0) ? (junk ? 32'hffffffff : 32'h0)
                                                      : 32'(base + wv[k][l]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Drains one matrix; optionally stalls 3 cycles at vector stall_at
    task automatic drain(input int base, input bit tp, input int stall_at);
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            chk("out_valid", out_valid, 1);
            chk("out_idx", out_idx, i);
            chk("out_data", out_data, vec(base, i, tp));
            chk("out_last", out_last, (i == N-1));
            chk("in_ready_drain", in_ready, 0);
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_data", out_data, vec(base, i, tp));
                    chk("stall_idx", out_idx, i);
                    chk("stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("post_drain_valid", out_valid, 0);
        chk("post_drain_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        transpose = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wave_cnt", wave_cnt, 0);
        chk("rst_out_idx", out_idx, 0);
        rst_n = 1'b1;

        // rows
        send(0, 1'b0, 1'b0, 7);
        drain(0, 1'b0, -1);

        // columns
        send(0, 1'b1, 1'b0, 7);
        drain(0, 1'b1, -1);

        // backpressure at vector 1
        send(0, 1'b0, 1'b0, 7);
        drain(0, 1'b0, 1);

        // abort after wavefront 3, then a fresh +0x10 matrix
        send(0, 1'b0, 1'b0, 4);
        chk("pre_abort_cnt", wave_cnt, 4);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = {4{32'hdeadbeef}};
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        chk("abort_cnt", wave_cnt, 0);
        chk("abort_in_ready", in_ready, 1);
        send(16, 1'b0, 1'b0, 7);
        drain(16, 1'b0, -1);

        // junk on inactive lanes
        send(0, 1'b0, 1'b1, 7);
        drain(0, 1'b0, -1);

        // reset during drain at out_idx 2
        send(0, 1'b0, 1'b0, 7);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("pre_rst_data", out_data, vec(0, i, 1'b0));
            @(negedge clk);
        end
        chk("pre_rst_idx", out_idx, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_idx", out_idx, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_ready", in_ready, 1);
        send(32, 1'b1, 1'b0, 7);
        drain(32, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
